// File: rtl/multu_iter.sv
// Iterative radix-2 shift-add unsigned multiplier for the MULTU path.
// One multiplier bit per clock; shares the divider's start/busy handshake.
module multu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   input  logic             start,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;
   logic             r_carry;
   logic [CW-1:0]    r_count;
   logic             r_done;
   logic [WIDTH:0]   w_sum;

   // r_carry is always zero here, so this equals {1'b0, acc_hi} + addend
   assign w_sum = {r_carry, r_acc_hi}
                + (r_acc_lo[0] ? {1'b0, r_mcand} : '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_mcand  <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_carry  <= 1'b0;
         r_count  <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_state  <= RUN;
            r_mcand  <= multiplicand;
            r_acc_hi <= '0;
            r_acc_lo <= multiplier;
            r_carry  <= 1'b0;
            r_count  <= '0;
         end else if (r_state == RUN) begin
            {r_carry, r_acc_hi, r_acc_lo} <=
               {1'b0, w_sum, r_acc_lo[WIDTH-1:1]};
            r_count <= r_count + CW'(1);
            if (r_count == CW'(WIDTH - 1)) begin
               r_state <= IDLE;
               r_done  <= 1'b1;
            end
         end
      end
   end

   assign hi   = r_acc_hi;
   assign lo   = r_acc_lo;
   assign busy = (r_state == RUN);
   assign done = r_done;

endmodule

// File: tb/tb_multu_iter.sv
// Randomised self-checking bench for multu_iter.
// Expected products come from plain 64-bit multiplication.
module tb_multu_iter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] multiplicand = '0;
   logic [31:0] multiplier = '0;
   logic        start = 1'b0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   multu_iter #(.WIDTH(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .start        (start),
      .hi           (hi),
      .lo           (lo),
      .busy         (busy),
      .done         (done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] x;
      logic [63:0] y;
      x = {32'd0, a};
      y = {32'd0, b};
      return x * y;
   endfunction

   // Called at a negedge; returns at the negedge after the load edge.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Returns at the negedge where done should be high.
   task automatic wait_done(input string tag, input logic [63:0] exp,
                            input bit scramble);
      int cyc = 0;
      int nd  = 0;
      while (busy && cyc < 100) begin
         if (done) nd++;
         if (scramble) begin
            multiplicand = $urandom;
            multiplier   = $urandom;
         end
         cyc++;
         @(negedge clock);
      end
      chk({tag, "_busycyc"}, 64'(cyc), 64'd32);
      chk({tag, "_early_done"}, 64'(nd), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_prod"}, {hi, lo}, exp);
   endtask

   task automatic one_op(input string tag, input logic [31:0] a,
                         input logic [31:0] b);
      @(negedge clock);
      start_op(a, b);
      chk({tag, "_busy0"}, 64'(busy), 64'd1);
      wait_done(tag, ref_mul(a, b), 1'b0);
      @(negedge clock);
      chk({tag, "_done_fall"}, 64'(done), 64'd0);
      chk({tag, "_hold"}, {hi, lo}, ref_mul(a, b));
   endtask

   initial begin
      int nd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] na;
      logic [31:0] nb;

      repeat (3) @(negedge clock);
      chk("rst_out", {31'd0, busy, 31'd0, done}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      reset = 1'b0;

      one_op("m3x5", 32'd3, 32'd5);
      chk("m3x5_lit", {hi, lo}, 64'h0000_0000_0000_000F);
      one_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("ones_lit", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      one_op("msb2", 32'h8000_0000, 32'd2);
      chk("msb2_lit", {hi, lo}, 64'h0000_0001_0000_0000);
      one_op("zero_a", 32'd0, 32'h1234_5678);
      one_op("zero_b", 32'h1234_5678, 32'd0);
      one_op("one", 32'd1, 32'hDEAD_BEEF);
      chk("one_lit", {hi, lo}, 64'h0000_0000_DEAD_BEEF);

      // restart mid-operation
      @(negedge clock);
      start_op(32'd7, 32'd9);
      nd = 0;
      repeat (9) begin
         if (done) nd++;
         @(negedge clock);
      end
      chk("rst_first_done", 64'(nd), 64'd0);
      start_op(32'h0001_0000, 32'h0001_0000);
      wait_done("restart", 64'h0000_0001_0000_0000, 1'b0);

      // async reset between edges mid-operation
      @(negedge clock);
      start_op(32'hABCD_1234, 32'h5678_9ABC);
      repeat (14) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_hilo", {hi, lo}, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      nd = 0;
      repeat (40) begin
         @(negedge clock);
         if (done || busy) nd++;
      end
      chk("arst_idle", 64'(nd), 64'd0);
      chk("arst_hold", {hi, lo}, 64'd0);

      // back-to-back with random operands, scrambling inputs while busy
      a = $urandom;
      b = $urandom;
      @(negedge clock);
      start_op(a, b);
      for (int i = 0; i < 1000; i++) begin
         wait_done("rnd", ref_mul(a, b), 1'b1);
         if (i == 999) break;
         na = $urandom;
         nb = $urandom;
         if (i % 4 == 0) begin
            na = {16'd0, na[15:0]};
         end
         if (i % 7 == 0) begin
            nb = 32'hFFFF_FFFF;
         end
         if (i % 2 == 0) begin
            start_op(na, nb);
            chk("b2b_done_fall", 64'(done), 64'd0);
         end else begin
            @(negedge clock);
            chk("rnd_hold", {hi, lo}, ref_mul(a, b));
            start_op(na, nb);
         end
         a = na;
         b = nb;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
